cam_ctrl: RTL and testbench

Sequencing controller and arbiter for the 16-entry translation CAM (key = {vpn[3:0], pid[3:0]}, data = 8-bit physical page). Two lookup requesters (fetch and data side) and one management port (page-table refill / OS) share the CAM's single command interface. The block serializes their commands, enforces the CAM's outrdy/outvalid/pagefault handshake, and returns per-requester responses. It also implements a per-PID flush as an internal delete loop.

---
 rtl/cam_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_cam_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_ctrl.sv
// Sequencing controller and arbiter for the 16-entry translation CAM.
// Serializes two lookup ports and one management port (write/delete/PID flush) onto the CAM's single command interface.
module cam_ctrl #(
    parameter int FLUSH_VPNS  = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lk0_req,
    input  logic [7:0] lk0_key,
    output logic       lk0_ack,
    output logic       lk0_rvalid,
    output logic       lk0_hit,
    output logic [7:0] lk0_pa,
    input  logic       lk1_req,
    input  logic [7:0] lk1_key,
    output logic       lk1_ack,
    output logic       lk1_rvalid,
    output logic       lk1_hit,
    output logic [7:0] lk1_pa,
    input  logic       mg_req,
    input  logic [1:0] mg_op,
    input  logic [7:0] mg_key,
    input  logic [7:0] mg_data,
    output logic       mg_ack,
    output logic       mg_done,
    output logic [1:0] cam_cmd,
    output logic [7:0] cam_key,
    output logic [7:0] cam_datain,
    input  logic [7:0] cam_dataout,
    input  logic       cam_outvalid,
    input  logic       cam_pagefault,
    input  logic       cam_outrdy,
    output logic       busy,
    output logic [7:0] fault_cnt,
    output logic       to_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        FL_ISSUE,
        FL_WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LAST_VPN = 4'(FLUSH_VPNS - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic       rr_lk1_last;
    logic       owner_lk1;
    logic       hit_r;
    logic [7:0] pa_r;
    logic [7:0] timer;
    logic [3:0] fl_vpn;
    logic [3:0] fl_pid;

    logic mg_valid;
    logic cmd_cycle;
    logic grant_mg;
    logic grant_lk0;
    logic grant_lk1;
    logic rd_resp;
    logic rd_timeout;
    logic wr_done;
    logic fl_issue;
    logic fl_next;
    logic fl_done;

    assign mg_valid  = mg_req && (mg_op != 2'b00);
    assign cmd_cycle = (cam_cmd != 2'b00);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The CAM's outrdy is meaningless while our own command is on the bus, so
    // write/delete completion only looks at it once cam_cmd has returned to idle.
    always_comb begin
        state_nxt  = state;
        grant_mg   = 1'b0;
        grant_lk0  = 1'b0;
        grant_lk1  = 1'b0;
        rd_resp    = 1'b0;
        rd_timeout = 1'b0;
        wr_done    = 1'b0;
        fl_issue   = 1'b0;
        fl_next    = 1'b0;
        fl_done    = 1'b0;
        case (state)
            IDLE: begin
                if (cam_outrdy) begin
                    if (mg_valid) begin
                        grant_mg  = 1'b1;
                        state_nxt = (mg_op == 2'b11) ? FL_ISSUE : WR_WAIT;
                    end else if (lk0_req && (!lk1_req || rr_lk1_last)) begin
                        grant_lk0 = 1'b1;
                        state_nxt = RD_WAIT;
                    end else if (lk1_req) begin
                        grant_lk1 = 1'b1;
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cam_pagefault || cam_outvalid) begin
                    rd_resp   = 1'b1;
                    state_nxt = RESP;
                end else if (timer == TO_LAST) begin
                    rd_timeout = 1'b1;
                    state_nxt  = RESP;
                end
            end
            WR_WAIT: begin
                if (!cmd_cycle && cam_outrdy) begin
                    wr_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FL_ISSUE: begin
                if (cam_outrdy) begin
                    fl_issue  = 1'b1;
                    state_nxt = FL_WAIT;
                end
            end
            FL_WAIT: begin
                if (!cmd_cycle && cam_outrdy) begin
                    if (fl_vpn == LAST_VPN) begin
                        fl_done   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        fl_next   = 1'b1;
                        state_nxt = FL_ISSUE;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All pulses default low each cycle; a pagefault beats a simultaneous outvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cam_cmd     <= 2'b00;
            cam_key     <= 8'h00;
            cam_datain  <= 8'h00;
            lk0_ack     <= 1'b0;
            lk1_ack     <= 1'b0;
            mg_ack      <= 1'b0;
            lk0_rvalid  <= 1'b0;
            lk1_rvalid  <= 1'b0;
            lk0_hit     <= 1'b0;
            lk1_hit     <= 1'b0;
            lk0_pa      <= 8'h00;
            lk1_pa      <= 8'h00;
            mg_done     <= 1'b0;
            fault_cnt   <= 8'h00;
            to_err      <= 1'b0;
            rr_lk1_last <= 1'b1;
            owner_lk1   <= 1'b0;
            hit_r       <= 1'b0;
            pa_r        <= 8'h00;
            timer       <= 8'h00;
            fl_vpn      <= 4'h0;
            fl_pid      <= 4'h0;
        end else begin
            cam_cmd    <= 2'b00;
            lk0_ack    <= 1'b0;
            lk1_ack    <= 1'b0;
            mg_ack     <= 1'b0;
            lk0_rvalid <= 1'b0;
            lk1_rvalid <= 1'b0;
            mg_done    <= 1'b0;

            if (grant_mg) begin
                mg_ack <= 1'b1;
                fl_vpn <= 4'h0;
                fl_pid <= mg_key[3:0];
                if (mg_op != 2'b11) begin
                    cam_cmd    <= mg_op;
                    cam_key    <= mg_key;
                    cam_datain <= mg_data;
                end
            end

            if (grant_lk0 || grant_lk1) begin
                cam_cmd     <= 2'b11;
                cam_key     <= grant_lk1 ? lk1_key : lk0_key;
                owner_lk1   <= grant_lk1;
                rr_lk1_last <= grant_lk1;
                lk0_ack     <= grant_lk0;
                lk1_ack     <= grant_lk1;
                timer       <= 8'h00;
            end

            if (state == RD_WAIT) begin
                timer <= timer + 8'd1;
            end

            if (rd_resp) begin
                hit_r <= !cam_pagefault;
                pa_r  <= cam_pagefault ? 8'h00 : cam_dataout;
            end

            if (rd_timeout) begin
                hit_r  <= 1'b0;
                pa_r   <= 8'h00;
                to_err <= 1'b1;
            end

            if (state == RESP) begin
                if (owner_lk1) begin
                    lk1_rvalid <= 1'b1;
                    lk1_hit    <= hit_r;
                    lk1_pa     <= pa_r;
                end else begin
                    lk0_rvalid <= 1'b1;
                    lk0_hit    <= hit_r;
                    lk0_pa     <= pa_r;
                end
                if (!hit_r && (fault_cnt != 8'hFF)) begin
                    fault_cnt <= fault_cnt + 8'd1;
                end
            end

            if (wr_done || fl_done) begin
                mg_done <= 1'b1;
            end

            if (fl_issue) begin
                cam_cmd <= 2'b10;
                cam_key <= {fl_vpn, fl_pid};
            end

            if (fl_next) begin
                fl_vpn <= fl_vpn + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: a behavioural CAM answers the DUT's commands and a
// translation table built from management requests predicts every lookup response.
module tb_cam_ctrl;

    localparam int FLUSH_VPNS  = 16;
    localparam int TIMEOUT_CYC = 64;

    logic       clk;
    logic       rst;
    logic       lk0_req, lk1_req;
    logic [7:0] lk0_key, lk1_key;
    logic       lk0_ack, lk1_ack, lk0_rvalid, lk1_rvalid, lk0_hit, lk1_hit;
    logic [7:0] lk0_pa, lk1_pa;
    logic       mg_req;
    logic [1:0] mg_op;
    logic [7:0] mg_key, mg_data;
    logic       mg_ack, mg_done;
    logic [1:0] cam_cmd;
    logic [7:0] cam_key, cam_datain, cam_dataout;
    logic       cam_outvalid, cam_pagefault, cam_outrdy;
    logic       busy;
    logic [7:0] fault_cnt;
    logic       to_err;

    cam_ctrl #(.FLUSH_VPNS(FLUSH_VPNS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst),
        .lk0_req(lk0_req), .lk0_key(lk0_key), .lk0_ack(lk0_ack), .lk0_rvalid(lk0_rvalid),
        .lk0_hit(lk0_hit), .lk0_pa(lk0_pa),
        .lk1_req(lk1_req), .lk1_key(lk1_key), .lk1_ack(lk1_ack), .lk1_rvalid(lk1_rvalid),
        .lk1_hit(lk1_hit), .lk1_pa(lk1_pa),
        .mg_req(mg_req), .mg_op(mg_op), .mg_key(mg_key), .mg_data(mg_data),
        .mg_ack(mg_ack), .mg_done(mg_done),
        .cam_cmd(cam_cmd), .cam_key(cam_key), .cam_datain(cam_datain),
        .cam_dataout(cam_dataout), .cam_outvalid(cam_outvalid), .cam_pagefault(cam_pagefault),
        .cam_outrdy(cam_outrdy), .busy(busy), .fault_cnt(fault_cnt), .to_err(to_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {MODE_NORMAL, MODE_BOTH, MODE_SILENT} mode_t;
    typedef struct packed {
        logic       hit;
        logic [7:0] pa;
    } resp_t;

    mode_t       cam_mode;
    bit          cmem_v[256];
    logic [7:0]  cmem_d[256];
    bit          ref_v[256];
    logic [7:0]  ref_d[256];
    resp_t       exp_q0[$];
    resp_t       exp_q1[$];
    int          grant_log[$];
    logic [17:0] cmd_log[$];
    int cyc, rv_cnt0, rv_cnt1, done_cnt;
    int ack_cyc0, ack_cyc1, rv_cyc0, rv_cyc1, ack_cyc_mg, done_cyc;
    int exp_fault;
    int checks, errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic resp_t predict(input logic [7:0] key);
        resp_t r;
        r.hit = 1'b0;
        r.pa  = 8'h00;
        if (cam_mode == MODE_NORMAL && ref_v[key]) begin
            r.hit = 1'b1;
            r.pa  = ref_d[key];
        end
        return r;
    endfunction

    task automatic score(input int port);
        resp_t r;
        if (port == 1) begin
            check("lk1 rvalid expected", exp_q1.size() != 0, 1);
            if (exp_q1.size() != 0) begin
                r = exp_q1.pop_front();
                check("lk1 hit", lk1_hit, r.hit);
                check("lk1 pa", lk1_pa, r.pa);
            end else r.hit = 1'b1;
        end else begin
            check("lk0 rvalid expected", exp_q0.size() != 0, 1);
            if (exp_q0.size() != 0) begin
                r = exp_q0.pop_front();
                check("lk0 hit", lk0_hit, r.hit);
                check("lk0 pa", lk0_pa, r.pa);
            end else r.hit = 1'b1;
        end
        if (!r.hit && exp_fault < 255) exp_fault++;
    endtask

    // Behavioural CAM: stores what the DUT writes, stalls outrdy 1..3 cycles per command.
    initial begin
        int         pend;
        logic       pend_rd;
        logic [7:0] pend_key;
        pend = 0; pend_rd = 1'b0; pend_key = 8'h00;
        cam_outrdy = 1'b1; cam_outvalid = 1'b0; cam_pagefault = 1'b0; cam_dataout = 8'h00;
        for (int i = 0; i < 256; i++) begin cmem_v[i] = 1'b0; cmem_d[i] = 8'h00; end
        forever begin
            @(posedge clk); #1;
            cam_outvalid = 1'b0;
            cam_pagefault = 1'b0;
            if (!rst) begin
                pend = 0; pend_rd = 1'b0; cam_outrdy = 1'b1;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        cam_outrdy = 1'b1;
                        if (pend_rd && cam_mode == MODE_BOTH) begin
                            cam_outvalid = 1'b1; cam_pagefault = 1'b1; cam_dataout = 8'($urandom);
                        end else if (pend_rd && cam_mode == MODE_NORMAL) begin
                            if (cmem_v[pend_key]) begin
                                cam_outvalid = 1'b1; cam_dataout = cmem_d[pend_key];
                            end else begin
                                cam_pagefault = 1'b1; cam_dataout = 8'($urandom);
                            end
                        end
                    end
                end
                if (cam_cmd != 2'b00) begin
                    check("one outstanding", pend, 0);
                    pend_rd  = (cam_cmd == 2'b11);
                    pend_key = cam_key;
                    if (cam_cmd == 2'b01) begin cmem_v[cam_key] = 1'b1; cmem_d[cam_key] = cam_datain; end
                    if (cam_cmd == 2'b10) cmem_v[cam_key] = 1'b0;
                    pend = $urandom_range(1, 3);
                    cam_outrdy = 1'b0;
                end
            end
        end
    end

    // Monitor: predicts responses at accept time, scores them at rvalid, logs CAM commands.
    initial begin
        cyc = 0; rv_cnt0 = 0; rv_cnt1 = 0; done_cnt = 0; exp_fault = 0;
        ack_cyc0 = 0; ack_cyc1 = 0; rv_cyc0 = 0; rv_cyc1 = 0; ack_cyc_mg = 0; done_cyc = 0;
        for (int i = 0; i < 256; i++) begin ref_v[i] = 1'b0; ref_d[i] = 8'h00; end
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                if (lk0_ack) begin exp_q0.push_back(predict(lk0_key)); grant_log.push_back(0); ack_cyc0 = cyc; end
                if (lk1_ack) begin exp_q1.push_back(predict(lk1_key)); grant_log.push_back(1); ack_cyc1 = cyc; end
                if (mg_ack) begin
                    grant_log.push_back(2);
                    ack_cyc_mg = cyc;
                    if (mg_op == 2'b01) begin ref_v[mg_key] = 1'b1; ref_d[mg_key] = mg_data; end
                    if (mg_op == 2'b10) ref_v[mg_key] = 1'b0;
                    if (mg_op == 2'b11)
                        for (int v = 0; v < FLUSH_VPNS; v++) ref_v[{4'(v), mg_key[3:0]}] = 1'b0;
                end
                if (mg_done) begin done_cnt++; done_cyc = cyc; end
                if (cam_cmd != 2'b00) cmd_log.push_back({cam_cmd, cam_key, cam_datain});
                if (lk0_rvalid) begin rv_cnt0++; rv_cyc0 = cyc; score(0); end
                if (lk1_rvalid) begin rv_cnt1++; rv_cyc1 = cyc; score(1); end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic lookup(input int port, input logic [7:0] key);
        int  n0;
        bit  got;
        n0 = (port == 1) ? rv_cnt1 : rv_cnt0;
        if (port == 1) begin lk1_req = 1'b1; lk1_key = key; end
        else begin lk0_req = 1'b1; lk0_key = key; end
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            got = (port == 1) ? lk1_ack : lk0_ack;
        end
        lk0_req = 1'b0;
        lk1_req = 1'b0;
        check("lookup ack seen", got, 1);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            got = (((port == 1) ? rv_cnt1 : rv_cnt0) != n0);
        end
        check("lookup rvalid seen", got, 1);
    endtask

    task automatic mgmt(input logic [1:0] op, input logic [7:0] key, input logic [7:0] data);
        int d0;
        bit got;
        d0 = done_cnt;
        mg_req = 1'b1; mg_op = op; mg_key = key; mg_data = data;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin tick(); got = mg_ack; end
        mg_req = 1'b0;
        check("mg ack seen", got, 1);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin tick(); got = (done_cnt != d0); end
        check("mg done seen", got, 1);
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin tick(); got = !busy; end
        check("returns to idle", got, 1);
        tick();
    endtask

    initial begin
        int exp_seq[6];
        int n, d0, fl_cyc;
        bit got, mg_raised;
        checks = 0; errors = 0;
        cam_mode = MODE_NORMAL;
        rst = 1'b0;
        lk0_req = 1'b0; lk1_req = 1'b0; lk0_key = 8'h00; lk1_key = 8'h00;
        mg_req = 1'b0; mg_op = 2'b00; mg_key = 8'h00; mg_data = 8'h00;
        tick(); tick();
        check("reset cam_cmd", cam_cmd, 0);
        check("reset cam_key", cam_key, 0);
        check("reset cam_datain", cam_datain, 0);
        check("reset busy", busy, 0);
        check("reset fault_cnt", fault_cnt, 0);
        check("reset to_err", to_err, 0);
        check("reset outputs", {lk0_ack, lk1_ack, lk0_rvalid, lk1_rvalid, mg_ack, mg_done,
                                lk0_hit, lk1_hit, lk0_pa, lk1_pa}, 0);
        rst = 1'b1;
        tick();

        $display("[TB] write A4->3C then lookup");
        cmd_log.delete();
        mgmt(2'b01, 8'hA4, 8'h3C);
        check("write cmd count", cmd_log.size(), 1);
        if (cmd_log.size() != 0) check("write cmd", cmd_log[0], {2'b01, 8'hA4, 8'h3C});
        lookup(0, 8'hA4);
        check("lk0 A4 hit", lk0_hit, 1);
        check("lk0 A4 pa", lk0_pa, 8'h3C);

        $display("[TB] pagefault and dual-response cases");
        lookup(1, 8'hA0);
        check("lk1 A0 hit", lk1_hit, 0);
        check("fault_cnt after one miss", fault_cnt, 1);
        cam_mode = MODE_BOTH;
        lookup(0, 8'hA4);
        cam_mode = MODE_NORMAL;
        check("both asserted hit", lk0_hit, 0);
        check("fault_cnt after two misses", fault_cnt, 2);

        $display("[TB] round robin with management cut-in");
        exp_seq = '{1, 0, 2, 1, 0, 1};
        grant_log.delete();
        lk0_key = 8'hA4; lk1_key = 8'hA4; lk0_req = 1'b1; lk1_req = 1'b1;
        mg_raised = 1'b0;
        for (int i = 0; i < 400 && grant_log.size() < 6; i++) begin
            tick();
            if (!mg_raised && grant_log.size() == 2) begin
                mg_req = 1'b1; mg_op = 2'b01; mg_key = 8'h55; mg_data = 8'h77; mg_raised = 1'b1;
            end else if (mg_req && mg_ack) mg_req = 1'b0;
        end
        lk0_req = 1'b0; lk1_req = 1'b0; mg_req = 1'b0;
        wait_idle();
        check("grant count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("grant order %0d", i), grant_log[i], exp_seq[i]);
        lookup(1, 8'h55);
        check("lk1 55 pa", lk1_pa, 8'h77);

        $display("[TB] flush pid 4 with a lookup held");
        mgmt(2'b01, 8'h34, 8'h11);
        mgmt(2'b01, 8'hF4, 8'h22);
        mgmt(2'b01, 8'h35, 8'h33);
        cmd_log.delete();
        d0 = done_cnt;
        mg_req = 1'b1; mg_op = 2'b11; mg_key = 8'h04; mg_data = 8'h00;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin tick(); got = mg_ack; end
        mg_req = 1'b0;
        check("flush ack seen", got, 1);
        lk0_req = 1'b1; lk0_key = 8'h34;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin tick(); got = (done_cnt != d0); end
        check("flush done seen", got, 1);
        n = cmd_log.size();
        fl_cyc = done_cyc - ack_cyc_mg;
        check("flush delete count", n, FLUSH_VPNS);
        for (int i = 0; i < FLUSH_VPNS && i < n; i++)
            check($sformatf("flush cmd %0d", i), cmd_log[i][17:8], {2'b10, 4'(i), 4'h4});
        check("flush min duration", fl_cyc >= 2 * FLUSH_VPNS + 1, 1);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin tick(); got = lk0_ack; end
        lk0_req = 1'b0;
        check("held lookup granted", got, 1);
        check("lookup waited for flush", ack_cyc0 > done_cyc, 1);
        wait_idle();
        check("single flush done", done_cnt - d0, 1);
        lookup(1, 8'hF4);
        check("flushed F4 hit", lk1_hit, 0);
        lookup(0, 8'h35);
        check("pid5 survives pa", lk0_pa, 8'h33);

        $display("[TB] read timeout");
        cam_mode = MODE_SILENT;
        lookup(1, 8'hA4);
        cam_mode = MODE_NORMAL;
        check("timeout latency", rv_cyc1 - ack_cyc1, TIMEOUT_CYC + 1);
        check("to_err set", to_err, 1);
        check("timeout pa", lk1_pa, 0);
        lookup(0, 8'h35);
        check("to_err sticky", to_err, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 60; i++) begin
            int r;
            logic [7:0] k;
            r = $urandom_range(0, 9);
            k = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            if (r < 3) mgmt(2'b01, k, 8'($urandom));
            else if (r == 3) mgmt(2'b10, k, 8'h00);
            else lookup(int'($urandom_range(0, 1)), k);
        end
        check("fault_cnt model", fault_cnt, exp_fault);

        $display("[TB] fault counter saturation");
        for (int i = 0; i < 300; i++) lookup(i % 2, 8'hEF);
        check("fault_cnt saturated", fault_cnt, 255);
        check("fault_cnt model sat", fault_cnt, exp_fault);

        $display("[TB] reset during read wait");
        mgmt(2'b01, 8'hA4, 8'h5A);
        cam_mode = MODE_SILENT;
        n = rv_cnt1;
        lk1_req = 1'b1; lk1_key = 8'hA4;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin tick(); got = lk1_ack; end
        lk1_req = 1'b0;
        check("pre-reset ack", got, 1);
        tick(); tick(); tick();
        check("busy before reset", busy, 1);
        rst = 1'b0;
        #1;
        check("mid reset busy", busy, 0);
        check("mid reset cam_cmd", cam_cmd, 0);
        check("mid reset counters", {fault_cnt, to_err}, 0);
        check("mid reset lk1", {lk1_rvalid, lk1_hit, lk1_pa}, 0);
        exp_q0.delete(); exp_q1.delete(); exp_fault = 0;
        cam_mode = MODE_NORMAL;
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("no rvalid after reset", rv_cnt1, n);
        lookup(0, 8'hA4);
        check("post-reset hit", lk0_hit, 1);
        check("post-reset pa", lk0_pa, 8'h5A);
        check("post-reset fault_cnt", fault_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: run did not complete, %0d errors so far", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
